// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory request inputs and stall/flush control outputs of the pipeline stall sequencer.
// The controller sits on the slave modport, and the pipeline datapath sits on the master modport.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use;
  logic             br_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_write;
  logic             if_de_write;
  logic             if_de_flush;
  logic             de_ex_write;
  logic             de_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             mem_wb_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;

  modport master (
    output load_use, br_taken, mem_req, mem_ack,
    input  pc_write, if_de_write, if_de_flush, de_ex_write, de_ex_flush,
           ex_mem_write, mem_wb_write, mem_wb_bubble, stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    input  load_use, br_taken, mem_req, mem_ack,
    output pc_write, if_de_write, if_de_flush, de_ex_write, de_ex_flush,
           ex_mem_write, mem_wb_write, mem_wb_bubble, stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Mealy outputs (zero latency from the hazard inputs).
// A data-memory stall freezes every stage; a watchdog latches ERR, which holds the freeze until reset.
module pipeline_stall_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT, ERR} state_t;

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [TO_W-1:0]  wait_cnt, wait_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             freeze, flush_ev, timeout;
  logic             pc_write, if_de_write, if_de_flush, de_ex_write, de_ex_flush;
  logic             ex_mem_write, mem_wb_write, mem_wb_bubble;

  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    freeze        = 1'b0;
    flush_ev      = 1'b0;
    timeout       = 1'b0;
    pc_write      = 1'b1;
    if_de_write   = 1'b1;
    if_de_flush   = 1'b0;
    de_ex_write   = 1'b1;
    de_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_write  = 1'b1;
    mem_wb_bubble = 1'b0;

    unique case (state)
      RUN, LU_BUBBLE: begin
        if (bus.mem_req && !bus.mem_ack) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = TO_W'(1);
        end else if (bus.br_taken) begin
          // The instruction in DE is squashed, so its load-use hazard is moot
          flush_ev  = 1'b1;
          state_nxt = RUN;
        end else if (bus.load_use && state == RUN) begin
          pc_write    = 1'b0;
          if_de_write = 1'b0;
          de_ex_flush = 1'b1;
          state_nxt   = LU_BUBBLE;
        end else begin
          state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (!bus.mem_ack) begin
          freeze = 1'b1;
          if (MEM_TIMEOUT != 0 && wait_cnt == TIMEOUT_V) begin
            timeout   = 1'b1;
            state_nxt = ERR;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_cnt + TO_W'(1);
          end
        end else begin
          flush_ev  = bus.br_taken;
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      ERR: begin
        freeze  = 1'b1;
        timeout = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    if (flush_ev) begin
      if_de_flush = 1'b1;
      de_ex_flush = 1'b1;
    end
    if (freeze) begin
      pc_write      = 1'b0;
      if_de_write   = 1'b0;
      de_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end

    // Reset overrides everything so that no control pulse escapes while reset is held
    if (rst) begin
      pc_write      = 1'b0;
      if_de_write   = 1'b0;
      if_de_flush   = 1'b0;
      de_ex_write   = 1'b0;
      de_ex_flush   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_write  = 1'b0;
      mem_wb_bubble = 1'b0;
      timeout       = 1'b0;
      flush_ev      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!pc_write && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.if_de_write   = if_de_write;
  assign bus.if_de_flush   = if_de_flush;
  assign bus.de_ex_write   = de_ex_write;
  assign bus.de_ex_flush   = de_ex_flush;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.mem_wb_write  = mem_wb_write;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;
  assign bus.mem_timeout   = timeout;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: the default instance, plus a narrow-counter instance with a short watchdog.
// Expected control vectors are queued as stimulus is applied and then popped at the sampling edge.
module tb_pipeline_stall_ctrl;

  // {pc_write, if_de_write, if_de_flush, de_ex_write, de_ex_flush,
  //  ex_mem_write, mem_wb_write, mem_wb_bubble, mem_timeout}
  localparam logic [8:0] V_RUN = 9'b110101100;
  localparam logic [8:0] V_LU  = 9'b000111100;
  localparam logic [8:0] V_FRZ = 9'b000000010;
  localparam logic [8:0] V_BR  = 9'b111111100;
  localparam logic [8:0] V_TO  = 9'b000000011;
  localparam logic [8:0] V_RST = 9'b000000000;

  logic clk;
  logic rst;
  logic load_use, br_taken, mem_req, mem_ack;
  int   tests;
  int   fails;
  logic [8:0] exp_q[$];

  pipeline_stall_ctrl_if #(.CNT_W(32)) ifa ();
  pipeline_stall_ctrl_if #(.CNT_W(4))  ifb ();

  assign ifa.load_use = load_use;
  assign ifa.br_taken = br_taken;
  assign ifa.mem_req  = mem_req;
  assign ifa.mem_ack  = mem_ack;
  assign ifb.load_use = load_use;
  assign ifb.br_taken = br_taken;
  assign ifb.mem_req  = mem_req;
  assign ifb.mem_ack  = mem_ack;

  pipeline_stall_ctrl #(.CNT_W(32), .MEM_TIMEOUT(255), .TO_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  pipeline_stall_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4), .TO_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs_a();
    return {ifa.pc_write, ifa.if_de_write, ifa.if_de_flush, ifa.de_ex_write, ifa.de_ex_flush,
            ifa.ex_mem_write, ifa.mem_wb_write, ifa.mem_wb_bubble, ifa.mem_timeout};
  endfunction

  function automatic logic [8:0] outs_b();
    return {ifb.pc_write, ifb.if_de_write, ifb.if_de_flush, ifb.de_ex_write, ifb.de_ex_flush,
            ifb.ex_mem_write, ifb.mem_wb_write, ifb.mem_wb_bubble, ifb.mem_timeout};
  endfunction

  task automatic apply(input logic [3:0] v);
    {load_use, br_taken, mem_req, mem_ack} = v;
  endtask

  task automatic do_reset();
    apply(4'b0000);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    apply(4'b1111);
    rst = 1'b1;
    @(negedge clk);
    got = outs_a();
    tests++;
    if (got !== V_RST) begin fails++; $display("FAIL reset_outs_a: got %b expected %b", got, V_RST); end
    got = outs_b();
    tests++;
    if (got !== V_RST) begin fails++; $display("FAIL reset_outs_b: got %b expected %b", got, V_RST); end
    tests++;
    if (ifa.stall_cnt !== 32'd0 || ifa.flush_cnt !== 32'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", ifa.stall_cnt, ifa.flush_cnt);
    end
    do_reset();
  endtask

  // Runs a stimulus table against instance A (sel=0) or B (sel=1)
  task automatic test_seq(input string name, input int sel, input logic [3:0] in_v[$],
                          input logic [8:0] ex_v[$], input int exp_stall, input int exp_flush);
    logic [8:0] got, exp;
    int         sc, fc;
    do_reset();
    for (int i = 0; i < in_v.size(); i++) begin
      apply(in_v[i]);
      exp_q.push_back(ex_v[i]);
      @(negedge clk);
      got = (sel == 0) ? outs_a() : outs_b();
      exp = exp_q.pop_front();
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL %s step %0d: got %b expected %b", name, i, got, exp);
      end
      @(posedge clk);
      #1;
    end
    sc = (sel == 0) ? int'(ifa.stall_cnt) : int'(ifb.stall_cnt);
    fc = (sel == 0) ? int'(ifa.flush_cnt) : int'(ifb.flush_cnt);
    tests++;
    if (sc != exp_stall || fc != exp_flush) begin
      fails++; $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                        name, sc, fc, exp_stall, exp_flush);
    end
  endtask

  task automatic test_load_use();
    test_seq("load_use", 0, '{4'b1000, 4'b1000, 4'b0000}, '{V_LU, V_RUN, V_RUN}, 1, 0);
    test_seq("ack_same_cycle", 0, '{4'b1011, 4'b1000, 4'b0000}, '{V_LU, V_RUN, V_RUN}, 1, 0);
  endtask

  task automatic test_mem_stall();
    test_seq("mem_stall", 0, '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0000},
             '{V_FRZ, V_FRZ, V_FRZ, V_RUN, V_RUN}, 3, 0);
    test_seq("lu_then_mem", 0, '{4'b1000, 4'b1010, 4'b1011, 4'b1000, 4'b0000},
             '{V_LU, V_FRZ, V_RUN, V_LU, V_RUN}, 3, 0);
  endtask

  task automatic test_branch();
    test_seq("branch_lu", 0, '{4'b1100, 4'b0000, 4'b0110, 4'b0111, 4'b0000},
             '{V_BR, V_RUN, V_FRZ, V_BR, V_RUN}, 1, 2);
    test_seq("branch_in_wait", 0, '{4'b0110, 4'b0110, 4'b0110, 4'b0111, 4'b0000},
             '{V_FRZ, V_FRZ, V_FRZ, V_BR, V_RUN}, 3, 1);
  endtask

  task automatic test_timeout();
    logic [8:0] got;
    test_seq("timeout", 1,
             '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0111, 4'b1100},
             '{V_FRZ, V_FRZ, V_FRZ, V_FRZ, V_TO, V_TO, V_TO, V_TO}, 8, 0);
    rst = 1'b1;
    #1;
    got = outs_b();
    tests++;
    if (got !== V_RST) begin fails++; $display("FAIL timeout_rst: got %b expected %b", got, V_RST); end
    test_seq("after_err", 1, '{4'b0000, 4'b1000}, '{V_RUN, V_LU}, 1, 0);
  endtask

  task automatic test_saturate_and_reset();
    logic [8:0] got;
    do_reset();
    apply(4'b0010);
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (ifb.stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_b: got %0d expected 15", ifb.stall_cnt); end
    tests++;
    if (ifa.stall_cnt !== 32'd20) begin fails++; $display("FAIL stall_a20: got %0d expected 20", ifa.stall_cnt); end
    do_reset();
    apply(4'b0010);
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (ifa.stall_cnt !== 32'd2) begin fails++; $display("FAIL wait_cnt2: got %0d expected 2", ifa.stall_cnt); end
    rst = 1'b1;
    #1;
    got = outs_a();
    tests++;
    if (got !== V_RST || ifa.stall_cnt !== 32'd0 || ifb.stall_cnt !== 4'd0) begin
      fails++; $display("FAIL rst_mid_wait: got %b stall=%0d/%0d expected %b stall=0/0",
                        got, ifa.stall_cnt, ifb.stall_cnt, V_RST);
    end
    test_seq("post_rst_run", 0, '{4'b0000, 4'b0001}, '{V_RUN, V_RUN}, 0, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    apply(4'b0000);
    test_reset();
    test_load_use();
    test_mem_stall();
    test_branch();
    test_timeout();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
